// File: rtl/spi_adc_pkg.sv
// Shared constants for the ADC-side SPI responder and its initiator:
// frame width default, SPI mode and FSM state encoding.
package spi_adc_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Mode 0: sck idles low, data sampled on the rising edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for one SPI pin plus rise/fall pulses on the synchronised level.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// ADC-side SPI mode-0 responder: one-entry sample holding register feeding a
// shift register clocked by oversampled spi_sck edges.
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int   DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_sck,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  state_e                state;
  logic [DATA_WIDTH-1:0] holding;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] last_sent;
  logic [DATA_WIDTH-1:0] frame_word;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  start;
  logic                  load;

  // An empty holding register replays the previous frame's word
  assign next_word    = hold_full ? holding : last_sent;
  assign start        = (state == ST_IDLE) & cs_fall;
  assign sample_ready = ~hold_full | start;
  assign load         = sample_valid & sample_ready;
  assign spi_miso_oe  = ~cs_level;
  assign frame_active = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      holding     <= '0;
      hold_full   <= 1'b0;
      last_sent   <= '0;
      frame_word  <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      spi_miso    <= IDLE_MISO;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;

      // A load in the start cycle lands after the frame has taken the old word
      if (load) begin
        holding   <= sample_data;
        hold_full <= 1'b1;
      end else if (start) begin
        hold_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          spi_miso <= IDLE_MISO;
          if (cs_fall) begin
            shift_reg  <= next_word;
            frame_word <= next_word;
            underrun   <= ~hold_full;
            bit_cnt    <= '0;
            spi_miso   <= next_word[DATA_WIDTH-1];
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // cs_n rising takes priority over any sck edge in the same cycle
          if (cs_rise) begin
            frame_abort <= 1'b1;
            last_sent   <= frame_word;
            spi_miso    <= IDLE_MISO;
            state       <= ST_IDLE;
          end else if (sck_rise) begin
            if (bit_cnt != CNT_W'(DATA_WIDTH)) bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              frame_done <= 1'b1;
              last_sent  <= frame_word;
              spi_miso   <= IDLE_MISO;
              state      <= ST_DONE;
            end
          end else if (sck_fall) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], IDLE_MISO};
            spi_miso  <= shift_reg[DATA_WIDTH-2];
          end
        end
        ST_DONE: begin
          spi_miso <= IDLE_MISO;
          if (cs_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: directed frame table, corner sequences, then
// random frames predicted by a word-level holding/last-sent model.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, frame_active, frame_done, frame_abort, underrun;

  int errors = 0;
  int checks = 0;
  int n_done, n_abort, n_under;
  logic clr_cnt = 1'b0;

  // Word-level model of what the responder should send
  logic [15:0] m_hold = '0;
  logic [15:0] m_last = '0;
  bit          m_full = 1'b0;

  spi_adc_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_cs_n     (spi_cs_n),
    .spi_sck      (spi_sck),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_cnt) begin
      n_done  <= 0;
      n_abort <= 0;
      n_under <= 0;
    end else begin
      n_done  <= n_done + int'(frame_done);
      n_abort <= n_abort + int'(frame_abort);
      n_under <= n_under + int'(underrun);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_load(input logic [15:0] d);
    m_hold = d;
    m_full = 1'b1;
  endtask

  task automatic model_frame(output logic [15:0] w, output bit u);
    w = m_full ? m_hold : m_last;
    u = !m_full;
    m_last = w;
    m_full = 1'b0;
  endtask

  task automatic load_sample(input logic [15:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (sample_ready) begin
        @(posedge clk);
        #1 sample_valid = 1'b0;
        ok = 1'b1;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("load_handshake", int'(ok), 1);
  endtask

  task automatic clear_counts();
    @(negedge clk) clr_cnt = 1'b1;
    @(negedge clk) clr_cnt = 1'b0;
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Mode 0 at clk/8: capture miso just before each rising sck edge
  task automatic frame_bits(input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[14:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame_end();
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_frame(input bit ld, input logic [15:0] d, input int n,
                          input logic [15:0] exp_w, input bit exp_u);
    logic [15:0] cap;
    if (ld) load_sample(d);
    clear_counts();
    frame_begin();
    chk("oe_in_frame", int'(spi_miso_oe), 1);
    chk("active_in_frame", int'(frame_active), 1);
    frame_bits(n, cap);
    if (n == 16) chk("miso_idle_in_done", int'(spi_miso), 0);
    frame_end();
    chk("frame_word", int'(cap), int'(exp_w >> (16 - n)));
    chk("frame_done_cnt", n_done, (n == 16) ? 1 : 0);
    chk("frame_abort_cnt", n_abort, (n == 16) ? 0 : 1);
    chk("underrun_cnt", n_under, int'(exp_u));
    chk("oe_after", int'(spi_miso_oe), 0);
    chk("active_after", int'(frame_active), 0);
    chk("ready_after", int'(sample_ready), 1);
  endtask

  typedef struct {
    bit          ld;
    logic [15:0] data;
    int          nbits;
    logic [15:0] exp_w;
    bit          exp_u;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] w, cap;
    bit          u, got, ld;
    int          n;

    vecs[0] = '{1'b0, 16'h0000, 16, 16'h0000, 1'b1};
    vecs[1] = '{1'b1, 16'hA5C3, 16, 16'hA5C3, 1'b0};
    vecs[2] = '{1'b1, 16'h1234, 16, 16'h1234, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 16, 16'h1234, 1'b1};
    vecs[4] = '{1'b1, 16'hBEEF,  7, 16'hBEEF, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 16, 16'hBEEF, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_miso", int'(spi_miso), 0);
    chk("rst_oe", int'(spi_miso_oe), 0);
    chk("rst_ready", int'(sample_ready), 1);
    chk("rst_active", int'(frame_active), 0);
    chk("rst_pulses", int'({frame_done, frame_abort, underrun}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].ld) model_load(vecs[i].data);
      model_frame(w, u);
      do_frame(vecs[i].ld, vecs[i].data, vecs[i].nbits, vecs[i].exp_w, vecs[i].exp_u);
    end

    // Load coinciding with frame start: frame sends the old held word
    load_sample(16'h8000);
    model_load(16'h8000);
    chk("ready_when_full", int'(sample_ready), 0);
    clear_counts();
    sample_data  = 16'h0001;
    sample_valid = 1'b1;
    spi_cs_n     = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (sample_ready) begin
        @(posedge clk);
        #1 sample_valid = 1'b0;
        got = 1'b1;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    frame_bits(16, cap);
    frame_end();
    chk("start_load_handshake", int'(got), 1);
    chk("start_load_word", int'(cap), 16'h8000);
    chk("start_load_underrun", n_under, 0);
    chk("start_load_done", n_done, 1);
    chk("start_load_ready", int'(sample_ready), 0);
    model_frame(w, u);
    model_load(16'h0001);
    model_frame(w, u);
    do_frame(1'b0, 16'h0, 16, w, u);

    // Reset in the middle of a frame
    load_sample(16'h5A5A);
    model_load(16'h5A5A);
    clear_counts();
    frame_begin();
    frame_bits(5, cap);
    chk("pre_reset_bits", int'(cap), int'(16'h5A5A >> 11));
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    #1;
    chk("midrst_oe", int'(spi_miso_oe), 0);
    chk("midrst_active", int'(frame_active), 0);
    chk("midrst_ready", int'(sample_ready), 1);
    chk("midrst_miso", int'(spi_miso), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_full = 1'b0; m_hold = '0; m_last = '0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", int'(frame_active), 0);
    model_load(16'hC3C3);
    model_frame(w, u);
    do_frame(1'b1, 16'hC3C3, 16, w, u);

    // Random frames against the model
    for (int r = 0; r < 12; r++) begin
      logic [15:0] d;
      d  = 16'($urandom);
      ld = !m_full && ($urandom_range(0, 1) == 1);
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      if (ld) model_load(d);
      model_frame(w, u);
      do_frame(ld, d, n, w, u);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
